// File: rtl/binomial_unfilter_if.sv
// Streaming valid/ready bundle for binomial_unfilter: filtered samples in, recovered samples out.
// master drives samples in and accepts results; slave is the unfilter block.
interface binomial_unfilter_if #(
  parameter int unsigned DW = 8
) ();
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/binomial_unfilter.sv
// Inverse of the N-stage binomial filter: N cascaded stages, each computing x[n] = y[n] - x[n-1] mod 2^DW.
// Optional BINOMIAL_UNFILTER_CLR_EN adds a clr port for a synchronous stream restart.
module binomial_unfilter #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef BINOMIAL_UNFILTER_CLR_EN
  input  logic clr,
`endif
  binomial_unfilter_if.slave strm
);

  logic [DW-1:0] d [N];
  logic [N-1:0]  v;
  logic [DW-1:0] stg_in_d [N];
  logic [N-1:0]  stg_in_v;
  logic          adv;

  // The whole pipeline moves together; it only freezes when the output beat is stuck.
  assign adv = strm.out_ready | ~v[N-1];

`ifdef BINOMIAL_UNFILTER_CLR_EN
  assign strm.in_ready = adv & ~clr;
`else
  assign strm.in_ready = adv;
`endif

  assign strm.out_data  = d[N-1];
  assign strm.out_valid = v[N-1];

  // Stage k is fed by the upstream port for k=0, else by stage k-1.
  always_comb begin
    stg_in_d[0] = strm.in_data;
    stg_in_v[0] = strm.in_valid;
    for (int unsigned k = 1; k < N; k++) begin
      stg_in_d[k] = d[k-1];
      stg_in_v[k] = v[k-1];
    end
  end

  // d_k doubles as history; bubbles advance the valid bits but leave history untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) d[k] <= '0;
      v <= '0;
`ifdef BINOMIAL_UNFILTER_CLR_EN
    end else if (clr) begin
      for (int unsigned k = 0; k < N; k++) d[k] <= '0;
      v <= '0;
`endif
    end else if (adv) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (stg_in_v[k]) d[k] <= DW'(stg_in_d[k] - d[k]);
      end
      v <= stg_in_v;
    end
  end

endmodule

// File: tb/tb_binomial_unfilter.sv
// Self-checking bench for binomial_unfilter: directed vector table (N=4 and N=1) plus
// scoreboarded sequences against a forward binomial model (gaps, stalls, reset, clr).
module tb_binomial_unfilter;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
`ifdef BINOMIAL_UNFILTER_CLR_EN
  logic clr;
`endif
  always #5 clk = ~clk;

  binomial_unfilter_if #(.DW(DW)) b4 ();
  binomial_unfilter_if #(.DW(DW)) b1 ();

  binomial_unfilter #(.N(4), .DW(DW)) dut4 (
    .clk(clk),
    .rst(rst),
`ifdef BINOMIAL_UNFILTER_CLR_EN
    .clr(clr),
`endif
    .strm(b4.slave)
  );

  binomial_unfilter #(.N(1), .DW(DW)) dut1 (
    .clk(clk),
    .rst(rst),
`ifdef BINOMIAL_UNFILTER_CLR_EN
    .clr(clr),
`endif
    .strm(b1.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_out  = 0;

  typedef struct {
    bit         sel;   // 0: N=4 instance, 1: N=1 instance
    logic       iv;
    logic [7:0] y;
    logic       ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[$];

  logic [7:0] exp_q[$];
  logic [7:0] fprev[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Forward filter y = (1+z^-1)^4 x, built from cascaded two-tap adders.
  function automatic logic [7:0] fwd_peek(input logic [7:0] x);
    logic [7:0] a;
    a = x;
    for (int k = 0; k < 4; k++) a = 8'(a + fprev[k]);
    return a;
  endfunction

  task automatic fwd_commit(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] t;
    a = x;
    for (int k = 0; k < 4; k++) begin
      t = 8'(a + fprev[k]);
      fprev[k] = a;
      a = t;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int k = 0; k < 4; k++) fprev[k] = 8'h00;
  endtask

  // One cycle on the N=4 instance: drive at negedge, account for both handshakes before posedge.
  task automatic step(input logic iv, input logic [7:0] y, input logic [7:0] xexp,
                      input logic ordy, output logic acc);
    logic [7:0] e;
    @(negedge clk);
    b4.in_valid  = iv;
    b4.in_data   = y;
    b4.out_ready = ordy;
    #1;
    if (b4.out_valid && ordy) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_beat: got data %0h expected no beat", b4.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", 32'(b4.out_data), 32'(e));
      end
    end
    acc = iv && b4.in_ready;
    if (acc) begin
      n_acc++;
      exp_q.push_back(xexp);
    end
  endtask

  task automatic send_x(input logic [7:0] x, input logic ordy);
    logic acc;
    logic [7:0] y;
    y = fwd_peek(x);
    acc = 1'b0;
    for (int r = 0; r < 64 && !acc; r++) step(1'b1, y, x, (r == 0) ? ordy : 1'b1, acc);
    chk("send_accept", 32'(acc), 32'd1);
    fwd_commit(x);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 8'h00, 1'b1, acc);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) step(1'b0, 8'h00, 8'h00, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    b4.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic add(input bit sel, input logic iv, input logic [7:0] y,
                     input logic ev, input logic [7:0] ed);
    vec_t r;
    r.sel = sel; r.iv = iv; r.y = y; r.ev = ev; r.ed = ed;
    tbl.push_back(r);
  endtask

  initial begin
    logic acc;
    logic [7:0] imp_y[5];
    logic [7:0] imp_x[5];
    imp_y[0] = 8'd1; imp_y[1] = 8'd4; imp_y[2] = 8'd6; imp_y[3] = 8'd4; imp_y[4] = 8'd1;
    imp_x[0] = 8'd1; imp_x[1] = 8'd0; imp_x[2] = 8'd0; imp_x[3] = 8'd0; imp_x[4] = 8'd0;

    rst = 1'b1;
`ifdef BINOMIAL_UNFILTER_CLR_EN
    clr = 1'b0;
`endif
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    #1;
    chk("rst_out_valid4", 32'(b4.out_valid), 32'd0);
    chk("rst_out_data4",  32'(b4.out_data),  32'd0);
    chk("rst_in_ready4",  32'(b4.in_ready),  32'd1);
    chk("rst_out_valid1", 32'(b1.out_valid), 32'd0);
    chk("rst_out_data1",  32'(b1.out_data),  32'd0);
    chk("rst_in_ready1",  32'(b1.in_ready),  32'd1);

    // Impulse response on N=4: first beat 4 cycles after first accept.
    add(0, 1, 8'd1, 0, 8'd0);
    add(0, 1, 8'd4, 0, 8'd0);
    add(0, 1, 8'd6, 0, 8'd0);
    add(0, 1, 8'd4, 1, 8'd1);
    add(0, 1, 8'd1, 1, 8'd0);
    add(0, 1, 8'd0, 1, 8'd0);
    add(0, 1, 8'd0, 1, 8'd0);
    add(0, 0, 8'd0, 1, 8'd0);
    add(0, 0, 8'd0, 1, 8'd0);
    add(0, 0, 8'd0, 1, 8'd0);
    add(0, 0, 8'd0, 0, 8'd0);
    // N=1 wrap/borrow.
    add(1, 1, 8'h01, 1, 8'h01);
    add(1, 1, 8'h00, 1, 8'hFF);
    add(1, 1, 8'h05, 1, 8'h06);
    add(1, 1, 8'h05, 1, 8'hFF);
    add(1, 0, 8'h00, 0, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      b4.out_ready = 1'b1;
      b1.out_ready = 1'b1;
      b4.in_valid = (tbl[i].sel == 1'b0) ? tbl[i].iv : 1'b0;
      b1.in_valid = (tbl[i].sel == 1'b1) ? tbl[i].iv : 1'b0;
      b4.in_data  = tbl[i].y;
      b1.in_data  = tbl[i].y;
      #1;
      if (tbl[i].sel) chk($sformatf("vec%0d_in_ready", i), 32'(b1.in_ready), 32'd1);
      else            chk($sformatf("vec%0d_in_ready", i), 32'(b4.in_ready), 32'd1);
      @(posedge clk);
      #1;
      if (tbl[i].sel) begin
        chk($sformatf("vec%0d_out_valid", i), 32'(b1.out_valid), 32'(tbl[i].ev));
        if (tbl[i].ev) chk($sformatf("vec%0d_out_data", i), 32'(b1.out_data), 32'(tbl[i].ed));
      end else begin
        chk($sformatf("vec%0d_out_valid", i), 32'(b4.out_valid), 32'(tbl[i].ev));
        if (tbl[i].ev) chk($sformatf("vec%0d_out_data", i), 32'(b4.out_data), 32'(tbl[i].ed));
      end
    end

    // Random stream with input gaps and output backpressure.
    do_reset();
    n_acc = 0;
    n_out = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b0, 8'($urandom_range(0, 255)), 8'h00, 1'($urandom_range(0, 3) != 0), acc);
      else
        send_x(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
    end
    drain();
    chk("beat_count", 32'(n_out), 32'(n_acc));

    // Full stall with a valid output and a pending input.
    do_reset();
    for (int i = 1; i <= 6; i++) send_x(8'(i * 10), 1'b1);
    chk("stall_pre_valid", 32'(b4.out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, fwd_peek(8'd70), 8'd70, 1'b0, acc);
      chk("stall_no_accept", 32'(acc), 32'd0);
      chk("stall_in_ready", 32'(b4.in_ready), 32'd0);
      chk("stall_out_valid", 32'(b4.out_valid), 32'd1);
      chk("stall_out_data", 32'(b4.out_data), 32'(exp_q[0]));
    end
    send_x(8'd70, 1'b1);
    send_x(8'd80, 1'b1);
    drain();

    // Reset mid-stream discards in-flight samples and history.
    do_reset();
    send_x(8'd5, 1'b1);
    send_x(8'd6, 1'b1);
    send_x(8'd7, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    b4.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(b4.in_ready), 32'd1);
    model_clear();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, imp_y[i], imp_x[i], 1'b1, acc);
      chk("midrst_accept", 32'(acc), 32'd1);
    end
    drain();

`ifdef BINOMIAL_UNFILTER_CLR_EN
    // clr drops the concurrent input and empties the pipeline.
    send_x(8'd9, 1'b1);
    send_x(8'd3, 1'b1);
    @(negedge clk);
    clr = 1'b1;
    b4.in_valid = 1'b1;
    b4.in_data = 8'h55;
    #1;
    chk("clr_in_ready", 32'(b4.in_ready), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    b4.in_valid = 1'b0;
    #1;
    chk("clr_out_valid", 32'(b4.out_valid), 32'd0);
    model_clear();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, imp_y[i], imp_x[i], 1'b1, acc);
      chk("clr_accept", 32'(acc), 32'd1);
    end
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binomial_unfilter.md
Name: binomial_unfilter

Overview:
- Inverse (deconvolution) block for the N-stage binomial filter. Recovers the original sample stream x from the filtered stream y = (1+z^-1)^N · x.
- Built as N cascaded recursive stages. Each stage computes x[n] = y[n] - x[n-1], modulo 2^DW. Modular arithmetic makes it the exact inverse of the forward filter's wrap-around adders.
- Sits on the receive side of a binomial-filter link, with valid/ready streaming and stall support.

Parameters:
- N, 4, number of inverse stages; must equal the forward filter's N; N >= 1.
- DW, 8, sample data width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_data  in  DW  filtered sample y
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  DW  recovered sample x
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data

Behaviour:
- Single clock domain clk. Reset rst is synchronous, active-high, and sampled on the rising edge of clk.
- Reset values:
  - all stage data/history registers = 0
  - all stage valid bits = 0
  - out_valid = 0, out_data = 0
  - in_ready = 1 in the first cycle after reset
- Pipeline advance:
  - adv = out_ready | ~out_valid
  - in_ready = adv, combinational; no dependence on in_valid
  - Input accepted when in_valid & in_ready.
- Per-stage state, for stage k = 1..N: data register d_k (also serves as history) and valid bit v_k. Stage k's input is (in_data, in_valid) for k=1, else (d_{k-1}, v_{k-1}).
- On adv:
  - valid input: d_k <= input - d_k (DW-bit, wrap mod 2^DW), v_k <= 1
  - invalid input (bubble): d_k held, v_k <= 0
  - Bubbles never modify history.
- When adv=0: all d_k and v_k held (full stall). No sample is lost or duplicated.
- Outputs: out_data = d_N, out_valid = v_N.
- Latency: N cycles from acceptance to out_valid when out_ready is held high. Throughput: 1 sample/cycle.
- Arithmetic: unsigned DW-bit subtract; borrow is discarded; no saturation. History starts at 0, matching the forward filter's zero initial state.
- Boundaries:
  - Simultaneous out_ready=0 with out_valid=1 and in_valid=1: input is not accepted (in_ready=0); upstream must hold its data.
  - Bubble in mid-pipeline followed by stall: bubble position is preserved.
  - rst mid-stream: all in-flight samples are discarded and history is cleared. The next accepted sample is treated as stream sample 0.
  - N=1: single stage; latency 1.
- No combinational path from in_data to out_data.

Optional Feature:
- Macro: BINOMIAL_UNFILTER_CLR_EN.
- Defined:
  - Adds port clr (in, 1), a synchronous stream-restart.
  - When clr=1 at a clock edge, all d_k are zeroed and all v_k cleared, regardless of adv.
  - Any input presented that cycle is dropped and in_ready is forced to 0.
  - rst has priority over clr.
  - Purpose: re-align history at packet boundaries without a full reset.
- Not defined: port clr is absent; only rst clears history.

Test Plan:
1. N=4, DW=8, out_ready=1. Send 1,4,6,4,1,0,0 on consecutive cycles → out_data 1,0,0,0,0,0,0; first out_valid 4 cycles after the first accept.
2. N=1, DW=8. Send 0x01, 0x00, 0x05, 0x05 → out 0x01, 0xFF, 0x06, 0xFF. Exercises wrap/borrow.
3. N=4, DW=8, random x stream through a golden forward binomial model, with random in_valid gaps → out sequence equals x exactly; gaps produce no output beats.
4. N=4. Hold out_ready=0 for 5 cycles while out_valid=1 and in_valid=1 → in_ready=0, out_data stable, no input consumed; on release the sequence resumes intact.
5. N=4. Assert rst for 1 cycle mid-stream after 3 accepted samples → next cycle out_valid=0 and in_ready=1; resending 1,4,6,4,1 yields 1,0,0,0,0.
6. With BINOMIAL_UNFILTER_CLR_EN: pulse clr while in_valid=1 → in_ready=0 that cycle, pipeline empties, and the subsequent impulse-response input decodes to 1,0,0,0,0.
